// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: F-extension issue control covering decode, FPU start/kill, latency tracking and writeback.
// Define FPU_DIV_SQRT_EN to issue FDIV.S/FSQRT.S; otherwise both decode as illegal.
module fpu_issue_ctrl #(
   parameter int ADD_LAT  = 2,
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 12,
   parameter int SQRT_LAT = 14
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       id_valid,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_funct5,
   input  logic [4:0] id_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       flush,
   output logic       id_stall,
   output logic       fpu_start,
   output logic [3:0] fpu_op,
   output logic       fpu_kill,
   output logic       wb_fwrite,
   output logic       wb_xwrite,
   output logic [4:0] wb_rd,
   output logic       illegal_op,
   output logic       busy
);

   localparam logic [6:0] OPC_F_RTYPE = 7'b1010011;
   localparam logic [6:0] OPC_F_LOAD  = 7'b0000111;
   localparam logic [6:0] OPC_F_STORE = 7'b0100111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;

   localparam int MAX_AM = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
`ifdef FPU_DIV_SQRT_EN
   localparam int MAX_DS  = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
   localparam int MAX_LAT = (MAX_AM > MAX_DS) ? MAX_AM : MAX_DS;
`else
   localparam int MAX_LAT = MAX_AM;
`endif
   localparam int CW = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   // Codes 3 and 6 are never decoded unless div/sqrt is enabled, so truncation there is harmless.
   function automatic logic [CW-1:0] lat_of(input logic [3:0] code);
      case (code)
         4'd0, 4'd1: lat_of = CW'(ADD_LAT);
         4'd2:       lat_of = CW'(MUL_LAT);
         4'd3:       lat_of = CW'(DIV_LAT);
         4'd6:       lat_of = CW'(SQRT_LAT);
         default:    lat_of = CW'(1);
      endcase
   endfunction

   function automatic logic uses_int_rs1(input logic [6:0] opc, input logic [4:0] f5);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
         OPC_F_LOAD, OPC_F_STORE: uses_int_rs1 = 1'b1;
         OPC_F_RTYPE:             uses_int_rs1 = (f5 == 5'b11010) || (f5 == 5'b11110);
         default:                 uses_int_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_int_rs2(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_STORE, OPC_BRANCH: uses_int_rs2 = 1'b1;
         default:                       uses_int_rs2 = 1'b0;
      endcase
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      pend_rd_q, pend_rd_d;
   logic            pend_int_q, pend_int_d;
   logic            fpu_start_q, fpu_start_d;
   logic [3:0]      fpu_op_q, fpu_op_d;
   logic            fpu_kill_q, fpu_kill_d;
   logic            wb_fwrite_q, wb_fwrite_d;
   logic            wb_xwrite_q, wb_xwrite_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic            illegal_op_q, illegal_op_d;
   logic            busy_q, busy_d;

   logic [3:0]      dec_code_s;
   logic            dec_frtype_s, dec_fpu_s, dec_ill_s, dec_fmvsx_s, dec_int_tgt_s;
   logic            raw_fp_s, raw_int_s, waw_s, struct_s, stall_s, issue_s;

   // Instruction decode: FPU op code, illegal funct5 and fmv.s.x detection.
   always_comb begin
      dec_code_s   = 4'd0;
      dec_fpu_s    = 1'b0;
      dec_ill_s    = 1'b0;
      dec_fmvsx_s  = 1'b0;
      dec_frtype_s = (id_opcode == OPC_F_RTYPE);
      if (dec_frtype_s) begin
         dec_fpu_s = 1'b1;
         case (id_funct5)
            5'b00000: dec_code_s = 4'd0;
            5'b00001: dec_code_s = 4'd1;
            5'b00010: dec_code_s = 4'd2;
            5'b00100: dec_code_s = 4'd4;
            5'b00101: dec_code_s = 4'd5;
            5'b10100: dec_code_s = 4'd7;
            5'b11000: dec_code_s = 4'd8;
            5'b11010: dec_code_s = 4'd9;
`ifdef FPU_DIV_SQRT_EN
            5'b00011: dec_code_s = 4'd3;
            5'b01011: dec_code_s = 4'd6;
`endif
            5'b11100: dec_fpu_s = 1'b0;
            5'b11110: begin
               dec_fpu_s   = 1'b0;
               dec_fmvsx_s = 1'b1;
            end
            default: begin
               dec_fpu_s = 1'b0;
               dec_ill_s = 1'b1;
            end
         endcase
      end else begin
         dec_fpu_s = 1'b0;
      end
      dec_int_tgt_s = dec_fpu_s && ((dec_code_s == 4'd7) || (dec_code_s == 4'd8));
   end

   // Hazards against the single pending destination; it stays pending through the WB cycle.
   always_comb begin
      struct_s  = dec_fpu_s && (state_q == S_EXEC);
      raw_fp_s  = !pend_int_q &&
                  ((dec_frtype_s && ((id_rs1 == pend_rd_q) || (id_rs2 == pend_rd_q))) ||
                   ((id_opcode == OPC_F_STORE) && (id_rs2 == pend_rd_q)));
      raw_int_s = pend_int_q && (pend_rd_q != 5'd0) &&
                  ((uses_int_rs1(id_opcode, id_funct5) && (id_rs1 == pend_rd_q)) ||
                   (uses_int_rs2(id_opcode) && (id_rs2 == pend_rd_q)));
      waw_s     = !pend_int_q && (id_rd == pend_rd_q) &&
                  ((id_opcode == OPC_F_LOAD) || dec_fmvsx_s || (dec_fpu_s && !dec_int_tgt_s));
      stall_s   = id_valid && (state_q != S_IDLE) && !dec_ill_s &&
                  (struct_s || raw_fp_s || raw_int_s || waw_s);
      issue_s   = id_valid && dec_fpu_s && !stall_s && !flush && (state_q != S_EXEC);
   end

   // Next-state, latency counter and registered-output computation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_rd_d    = pend_rd_q;
      pend_int_d   = pend_int_q;
      fpu_op_d     = fpu_op_q;
      wb_rd_d      = wb_rd_q;
      fpu_start_d  = 1'b0;
      fpu_kill_d   = 1'b0;
      wb_fwrite_d  = 1'b0;
      wb_xwrite_d  = 1'b0;
      illegal_op_d = id_valid && dec_ill_s && !flush;
      busy_d       = (state_q != S_IDLE);
      if (flush) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         fpu_kill_d = (state_q != S_IDLE);
      end else begin
         case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_EXEC: begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_EXEC;
               end
            end
            S_WB: begin
               wb_fwrite_d = !pend_int_q;
               wb_xwrite_d = pend_int_q;
               wb_rd_d     = pend_rd_q;
               state_d     = S_IDLE;
               cnt_d       = '0;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
         if (issue_s) begin
            fpu_start_d = 1'b1;
            fpu_op_d    = dec_code_s;
            pend_rd_d   = id_rd;
            pend_int_d  = dec_int_tgt_s;
            cnt_d       = lat_of(dec_code_s) - CW'(1);
            if (lat_of(dec_code_s) == CW'(1)) begin
               state_d = S_WB;
            end else begin
               state_d = S_EXEC;
            end
         end else begin
            fpu_start_d = 1'b0;
         end
      end
   end

   // State, pending-register and output flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pend_rd_q    <= 5'd0;
         pend_int_q   <= 1'b0;
         fpu_start_q  <= 1'b0;
         fpu_op_q     <= 4'd0;
         fpu_kill_q   <= 1'b0;
         wb_fwrite_q  <= 1'b0;
         wb_xwrite_q  <= 1'b0;
         wb_rd_q      <= 5'd0;
         illegal_op_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pend_rd_q    <= pend_rd_d;
         pend_int_q   <= pend_int_d;
         fpu_start_q  <= fpu_start_d;
         fpu_op_q     <= fpu_op_d;
         fpu_kill_q   <= fpu_kill_d;
         wb_fwrite_q  <= wb_fwrite_d;
         wb_xwrite_q  <= wb_xwrite_d;
         wb_rd_q      <= wb_rd_d;
         illegal_op_q <= illegal_op_d;
         busy_q       <= busy_d;
      end
   end

   assign id_stall   = stall_s;
   assign fpu_start  = fpu_start_q;
   assign fpu_op     = fpu_op_q;
   assign fpu_kill   = fpu_kill_q;
   assign wb_fwrite  = wb_fwrite_q;
   assign wb_xwrite  = wb_xwrite_q;
   assign wb_rd      = wb_rd_q;
   assign illegal_op = illegal_op_q;
   assign busy       = busy_q;

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

- Sequential successor to the combinational RISC-V control unit; handles the F-extension compute path.
- Decodes F_RType instructions in the decode stage and issues them to the FPU as a one-cycle start pulse with the {fpuOp,aluOp} code.
- Tracks the in-flight operation with a per-op latency counter and generates the writeback pulse.
- Stalls decode on structural and register hazards against the single outstanding result.

## Interface
Parameters:
- ADD_LAT, default 2: cycles for FADD.S/FSUB.S (codes 0,1)
- MUL_LAT, default 3: cycles for FMUL.S (code 2)
- DIV_LAT, default 12: cycles for FDIV.S (code 3)
- SQRT_LAT, default 14: cycles for FSQRT.S (code 6)
- All other ops (4,5,7,8,9) take 1 cycle. Every latency is ≥1. Counter width is $clog2(max latency + 1).

Ports:
- clk, in, 1: clock
- reset_n, in, 1: asynchronous, active-low reset
- id_valid, in, 1: decode stage holds a valid instruction
- id_opcode, in, 7: instruction opcode
- id_funct5, in, 5: instruction funct5
- id_rd, id_rs1, id_rs2, in, 5 each: register fields
- flush, in, 1: pipeline squash
- id_stall, out, 1: hold decode stage (combinational)
- fpu_start, out, 1: one-cycle issue pulse
- fpu_op, out, 4: code 0–9 (add, sub, mul, div, sgnj, minmax, sqrt, cmp, cvt.w.s, cvt.s.w)
- fpu_kill, out, 1: one-cycle abort pulse to the FPU
- wb_fwrite, out, 1: write fp register file
- wb_xwrite, out, 1: write integer register file (codes 7, 8)
- wb_rd, out, 5: destination register
- illegal_op, out, 1: one-cycle pulse for an unsupported funct5
- busy, out, 1: state ≠ IDLE

## Operation
- FPU op: opcode 1010011 with funct5 in {00000, 00001, 00010, 00011, 00100, 00101, 01011, 10100, 11000, 11010}. fmv.s.x and fmv.x.s are not FPU ops and pass through without issue.
- Pending register: latched rd plus target file (fp, or int for codes 7/8), held from issue through WB.
- State machine has three states: IDLE, EXEC, WB.
  - IDLE: a valid, unstalled FPU op issues. Issue pulses fpu_start, registers fpu_op/rd, and loads cnt = LAT−1. Next state is WB if LAT = 1, else EXEC.
  - EXEC: cnt decrements each cycle. When cnt = 1, go to WB.
  - WB: wb_fwrite or wb_xwrite pulses with wb_rd. Issue is allowed in the same cycle (back-to-back), following the IDLE rules. Otherwise return to IDLE.
- id_stall = id_valid & state ≠ IDLE & (structural | RAW | WAW).
  - structural: the ID instruction is an FPU op and state = EXEC.
  - RAW, pending fp rd: matches rs1/rs2 of any F_RType, or rs2 of F_STORE (0100111).
  - RAW, pending int rd (≠ x0): matches rs1/rs2 of any opcode that uses integer sources.
  - WAW: F_LOAD (0000111), fmv.s.x or an FPU op targets the pending fp rd.
  - In WB, hazards are evaluated against the pending register; the register file is written at the end of the WB cycle.
- flush: synchronous and dominant. It forces IDLE, suppresses issue and writeback that cycle, and pulses fpu_kill if state was EXEC or WB.
- Unknown funct5 under F_RType: pulse illegal_op, no issue, no stall.

## Timing
- Reset values: state IDLE, cnt 0, and every registered output 0 (fpu_start, fpu_op, fpu_kill, wb_*, illegal_op, busy).
- Issue at cycle T: fpu_start is high at T (registered, visible in T+1). The wb pulse is visible exactly LAT cycles after fpu_start.
- Back-to-back: the WB cycle of op A can coincide with the start of op B.
- reset_n asserted mid-EXEC: immediate IDLE. No wb pulse and no fpu_kill.

## Configuration
- FPU_DIV_SQRT_EN defined: codes 3 and 6 issue with DIV_LAT and SQRT_LAT.
- FPU_DIV_SQRT_EN undefined:
  - funct5 00011 and 01011 are illegal: illegal_op pulses, no issue.
  - The DIV_LAT/SQRT_LAT parameters are ignored for counter width.

## Test plan
- FADD.S rd=f3, ADD_LAT=2, issued at cycle 10 -> fpu_start at 10, fpu_op=0; wb_fwrite with wb_rd=3 exactly 2 cycles later; busy deasserts the following cycle.
- FDIV.S rd=f5 followed by FMUL.S rs1=f5 -> id_stall held for 12 cycles; FMUL issues in the cycle after the wb pulse; fpu_op=2.
- FMUL rd=f1 then FADD rd=f2 with no dependence -> FADD stalls only during EXEC, issues in the FMUL WB cycle; both wb pulses observed.
- FCVT.W.S rd=x7, then ADD using x7 -> wb_xwrite with wb_rd=7 after 1 cycle; ADD stalled until after the WB cycle; rd=x0 causes no stall.
- flush at cycle 5 of FSQRT.S -> fpu_kill pulses once, no wb pulse, IDLE next cycle; a simultaneous id_valid FADD does not issue.
- Build without FPU_DIV_SQRT_EN, FDIV.S -> illegal_op pulse, no fpu_start; reset_n low mid-FMUL -> all outputs 0.
